mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore-style sequencing FSM for a multicycle version of the team's MIPS core.
- The instruction register, A/B/ALUOut/MDR registers and a unified instruction/data memory are shared across cycles instead of being replicated.
- The block reads the latched opcode/funct and emits per-cycle mux selects and write strobes for PC, IR, register file and memory.
- Memory accesses stall on a MemReady handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Opcode  input  6  IR[31:26], stable from the cycle after FETCH completes.
- Funct  input  6  IR[5:0].
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero=1 (beq).
- PCWriteCondNE  output  1  PC load if ALU Zero=0 (bne).
- IorD  output  1  memory address: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load instruction register.
- MemtoReg  output  2  write data: 00=ALUOut, 01=MDR, 10=PC.
- RegDst  output  2  write register: 00=rt, 01=rd, 10=$31.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  2  00=PC, 01=A, 10=zero-extended shamt.
- ALUSrcB  output  2  00=B, 01=const 4, 10=extended imm, 11=signext imm<<2.
- ExtZero  output  1  immediate zero-extended (andi/ori) instead of sign-extended.
- ALUOp  output  3  000=add, 001=sub, 100=or, 101=and, 110=lui, 111=R-type (use funct).
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A.
- Illegal  output  1  sticky unsupported-opcode flag.
- State  output  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, JR=13, ILLEGAL=15. State 14 is unused and goes to FETCH.
- Reset (asynchronous) sets State=FETCH. While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; all other outputs take their FETCH values.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=000. Dispatch on Opcode:
  - 0x00 with Funct 0x08 -> JR; 0x00 otherwise -> R_EXEC.
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
  - 0x04/0x05 -> BRANCH.
  - 0x02 -> JUMP; 0x03 -> JAL.
  - 0x08/0x0C/0x0D/0x0F -> I_EXEC.
  - Anything else -> ILLEGAL.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=000. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady, then FETCH. MemWrite stays asserted for every held cycle.
- R_EXEC: ALUSrcB=00, ALUOp=111. ALUSrcA=10 if Funct is 0x00 (sll) or 0x02 (srl), else 01. Then R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00. Then FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=001, PCSource=01. PCWriteCond=1 for 0x04, PCWriteCondNE=1 for 0x05. Then FETCH.
- I_EXEC: ALUSrcA=01, ALUSrcB=10. Then I_WB.
  - ALUOp: 000 for addi, 101 for andi, 100 for ori, 110 for lui.
  - ExtZero=1 for andi/ori.
- I_WB: RegWrite=1, RegDst=00, MemtoReg=00. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. $31 receives the pre-edge PC, which is already PC+4. Then FETCH.
- JR: PCWrite=1, PCSource=11. Then FETCH.
- ILLEGAL: Illegal=1, all strobes 0. Stays until reset.
- Cycle counts with MemReady tied to 1:
  - lw=5.
  - sw, R-type, I-type=4.
  - beq/bne, j, jal, jr=3.
- Each wait cycle on MemReady adds exactly 1 cycle.
- Reset asserted mid-instruction aborts it immediately; no strobe is issued after the asserting edge.

Test Plan:
- reset=1 then released, MemReady=0 for 3 cycles then 1: State=0 throughout the wait, IRWrite=PCWrite=0 during the wait, =1 in the MemReady cycle; State=1 next cycle.
- Opcode=0x00, Funct=0x20, MemReady=1: State sequence 0,1,6,7,0; RegWrite=1 and RegDst=01 only in state 7.
- Opcode=0x23 with MemReady low for 2 cycles in MEM_READ: sequence 0,1,2,3,3,3,4,0; IorD=1 in state 3; MemtoReg=01 in state 4.
- Opcode=0x05: in state 8, PCWriteCondNE=1, PCWriteCond=0, ALUOp=001, PCSource=01. Opcode=0x04 gives the opposite pair.
- Opcode=0x03: state 12 shows PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. Opcode=0x00 with Funct=0x08 visits state 13 with PCSource=11.
- Opcode=0x3F: ILLEGAL (15) is reached, Illegal=1 is held for 10 cycles with all strobes 0. Asserting reset mid-cycle forces State=0 asynchronously.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bus of the multicycle MIPS sequencer: decoded instruction fields
// and the memory handshake flow in, datapath selects and strobes flow out.
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCWriteCondNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtZero;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       Illegal;
  logic [3:0] State;

  // Control unit side: it consumes the instruction fields and drives the strobes.
  modport master (
    input  Opcode, Funct, MemReady,
    output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero,
           ALUOp, PCSource, Illegal, State
  );

  // Datapath side: it supplies the instruction fields and obeys the strobes.
  modport slave (
    output Opcode, Funct, MemReady,
    input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero,
           ALUOp, PCSource, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS core. Reads the latched
// opcode/funct and issues per-cycle mux selects and write strobes; memory
// states hold until MemReady.
module mips_multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                           clk,
  input  logic                           reset,
  mips_multicycle_control_if.master      bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13,
    UNUSED    = 4'd14,
    ILLEGAL   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_e state_q, state_d;

  // Raw strobes before the reset gate.
  logic pc_write, ir_write, reg_write, mem_write;

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= state_e'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Next-state: dispatch from DECODE, memory states wait on MemReady.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (bus.MemReady) state_d = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:                        state_d = (bus.Funct == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:                    state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:                  state_d = BRANCH;
          OP_J:                            state_d = JUMP;
          OP_JAL:                          state_d = JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = I_EXEC;
          default:                         state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR:  state_d = (bus.Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (bus.MemReady) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (bus.MemReady) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      I_EXEC:    state_d = I_WB;
      I_WB:      state_d = FETCH;
      JAL:       state_d = FETCH;
      JR:        state_d = FETCH;
      ILLEGAL:   state_d = ILLEGAL;
      default:   state_d = FETCH;
    endcase
  end

  // Moore outputs decoded from the current state; everything defaults to 0.
  always_comb begin
    pc_write          = 1'b0;
    ir_write          = 1'b0;
    reg_write         = 1'b0;
    mem_write         = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.PCWriteCondNE = 1'b0;
    bus.IorD          = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemtoReg      = '0;
    bus.RegDst        = '0;
    bus.ALUSrcA       = '0;
    bus.ALUSrcB       = '0;
    bus.ExtZero       = 1'b0;
    bus.ALUOp         = '0;
    bus.PCSource      = '0;
    bus.Illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        ir_write    = bus.MemReady;
        pc_write    = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        reg_write    = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        bus.IorD  = 1'b1;
      end
      R_EXEC: begin
        bus.ALUSrcA = (bus.Funct == FN_SLL || bus.Funct == FN_SRL) ? 2'b10 : 2'b01;
        bus.ALUOp   = 3'b111;
      end
      R_WB: begin
        reg_write  = 1'b1;
        bus.RegDst = 2'b01;
      end
      BRANCH: begin
        bus.ALUSrcA       = 2'b01;
        bus.ALUOp         = 3'b001;
        bus.PCSource      = 2'b01;
        bus.PCWriteCond   = (bus.Opcode == OP_BEQ);
        bus.PCWriteCondNE = (bus.Opcode == OP_BNE);
      end
      JUMP: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
      end
      I_EXEC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        case (bus.Opcode)
          OP_ANDI: begin bus.ALUOp = 3'b101; bus.ExtZero = 1'b1; end
          OP_ORI:  begin bus.ALUOp = 3'b100; bus.ExtZero = 1'b1; end
          OP_LUI:  bus.ALUOp = 3'b110;
          default: bus.ALUOp = 3'b000;
        endcase
      end
      I_WB: begin
        reg_write = 1'b1;
      end
      JAL: begin
        // $31 takes the current PC, which FETCH already advanced to PC+4.
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
        reg_write    = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b10;
      end
      JR: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b11;
      end
      ILLEGAL: begin
        bus.Illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // State-changing strobes are held off for as long as reset is high.
  always_comb begin
    bus.PCWrite  = pc_write  & ~reset;
    bus.IRWrite  = ir_write  & ~reset;
    bus.RegWrite = reg_write & ~reset;
    bus.MemWrite = mem_write & ~reset;
    bus.State    = state_q;
  end

endmodule
